sha_msg_sequencer: RTL and testbench
====================================

SHA_MSG_SEQUENCER -- requirements
Module: sha_msg_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_W, default 512, message block width in bits.
REQ-002 SHALL have parameter DIGEST_W, default 256, digest width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, input FIFO entries; power of two, >=2.
REQ-004 SHALL have parameter TIMEOUT, default 1024, max cycles from block issue to digest_valid.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 s_valid  in  1  input block valid.
REQ-009 s_ready  out  1  FIFO not full.
REQ-010 s_block  in  BLOCK_W  message block, already padded.
REQ-011 s_last  in  1  block is final block of its message.
REQ-012 core_block  out  BLOCK_W  block to SHA core.
REQ-013 core_init  out  1  one-cycle pulse: first block of message.
REQ-014 core_next  out  1  one-cycle pulse: continuation block.
REQ-015 core_ready  in  1  core idle, may accept init/next.
REQ-016 core_digest  in  DIGEST_W  core digest.
REQ-017 core_digest_valid  in  1  core digest valid.
REQ-018 m_valid  out  1  final message digest valid.
REQ-019 m_ready  in  1  downstream accepts digest.
REQ-020 m_digest  out  DIGEST_W  final message digest.
REQ-021 m_blk_count  out  16  blocks hashed in delivered message, saturating at 16'hFFFF.
REQ-022 err_timeout  out  1  sticky: core failed to return digest within TIMEOUT.

Function
REQ-023 Input write on s_valid && s_ready; {s_block, s_last} stored in FIFO; s_ready low when DEPTH entries held.
REQ-024 Simultaneous FIFO write and read when full SHALL not be accepted (s_ready depends only on occupancy).
REQ-025 FSM states: IDLE, ISSUE, WAIT, HOLD, ERR.
REQ-026 IDLE: FIFO non-empty -> pop head into core_block register, go ISSUE.
REQ-027 ISSUE: when core_ready, pulse core_init (first block of message) or core_next (otherwise) for exactly one cycle, go WAIT; else stay.
REQ-028 core_init and core_next SHALL never be high together, and never high outside ISSUE.
REQ-029 core_block SHALL remain stable from pop until core_digest_valid is seen in WAIT.
REQ-030 WAIT: on core_digest_valid, increment block counter; if popped block's s_last = 1, capture core_digest into m_digest, assert m_valid, go HOLD; else go IDLE, next block uses core_next.
REQ-031 WAIT: timeout counter reaches TIMEOUT without core_digest_valid -> set err_timeout, go ERR.
REQ-032 core_digest_valid outside WAIT SHALL be ignored.
REQ-033 HOLD: m_valid and m_digest stable until m_ready; on m_valid && m_ready drop m_valid, reset first-block flag and counter, go IDLE.
REQ-034 FIFO SHALL continue accepting input during WAIT and HOLD.
REQ-035 ERR: no core pulses; FIFO flushed; s_ready low; left only by reset.
REQ-036 m_blk_count SHALL hold the count of the delivered message while m_valid is high.
REQ-037 Minimum issue-to-issue gap: 2 cycles plus core latency; FIFO pop to core pulse 1 cycle when core_ready high.

Reset
REQ-038 On rst_n low, immediately: state IDLE, FIFO empty, s_ready 0 during reset then 1, core_init 0, core_next 0, core_block 0, m_valid 0, m_digest 0, m_blk_count 0, err_timeout 0, first-block flag 1.
REQ-039 Reset mid-message SHALL discard partial message; next accepted block issues core_init.

Structure
REQ-040 Shared package sha_pkg SHALL hold the state enum, default BLOCK_W/DIGEST_W constants, and a FIFO entry struct {block, last}.
REQ-041 FIFO SHALL be a sub-module sha_blk_fifo, parametrised by width and DEPTH.

Verification
REQ-042 Single-block message, core returns digest 64 cycles after init -> one core_init, zero core_next, m_valid with that digest, m_blk_count = 1.
REQ-043 Three-block message "abc...": blocks 0,1,2 with last on 2 -> pulse sequence init,next,next; m_blk_count = 3; m_digest equals third core_digest.
REQ-044 Back-to-back 5 single-block messages with m_ready held low 100 cycles -> s_ready falls after DEPTH entries buffered; no block lost; 5 digests delivered in order.
REQ-045 Core never asserts digest_valid, TIMEOUT = 16 -> err_timeout = 1 at cycle 16 after pulse; no further pulses; s_ready 0.
REQ-046 rst_n asserted during WAIT of block 2 of a 3-block message -> all outputs at reset values asynchronously; next block triggers core_init.
REQ-047 Spurious core_digest_valid in IDLE and HOLD -> no state change, m_digest unchanged.

Source files
------------

// File: rtl/sha_pkg.sv
// -----------------------------------------------------------------------------
// sha_pkg
// Shared definitions for the SHA message sequencer slice.
//   - seq_state_t  : sequencer FSM states
//   - SHA_BLOCK_W  : default message block width (bits)
//   - SHA_DIGEST_W : default digest width (bits)
//   - blk_entry_t  : FIFO entry layout {block, last} at default width
//   - sat_inc16    : saturating 16-bit increment for block counters
// -----------------------------------------------------------------------------
package sha_pkg;

    localparam int unsigned SHA_BLOCK_W  = 512;
    localparam int unsigned SHA_DIGEST_W = 256;
    localparam int unsigned SHA_CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_ERR
    } seq_state_t;

    // The FIFO stores the entry flattened as {block, last}; this struct
    // documents that layout and matches it bit-for-bit at default width.
    typedef struct packed {
        logic [SHA_BLOCK_W-1:0] block;
        logic                   last;
    } blk_entry_t;

    function automatic logic [SHA_CNT_W-1:0] sat_inc16(input logic [SHA_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sha_blk_fifo.sv
// -----------------------------------------------------------------------------
// sha_blk_fifo
// Synchronous FIFO holding padded message blocks plus their last flag.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_flush           synchronous clear of all entries
//   i_wr_en/i_wr_data write strobe and data (ignored when full)
//   i_rd_en           pop strobe (ignored when empty)
//   o_rd_data         head entry (valid when !o_empty)
//   o_full, o_empty   occupancy flags
// -----------------------------------------------------------------------------
module sha_blk_fifo #(
    parameter int unsigned WIDTH = 513,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/sha_msg_sequencer.sv
// -----------------------------------------------------------------------------
// sha_msg_sequencer
// Buffers padded message blocks and feeds them one at a time to a SHA core,
// issuing init for the first block of a message and next for continuations.
// The digest returned for a message's final block is presented downstream
// together with the number of blocks hashed.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_valid/s_ready         input block handshake
//   s_block, s_last         padded block and final-block flag
//   core_block              block presented to the core (stable until digest)
//   core_init, core_next    one-cycle start pulses to the core
//   core_ready              core idle
//   core_digest(_valid)     digest returned by the core
//   m_valid/m_ready         final digest handshake
//   m_digest, m_blk_count   final digest and block count (saturating)
//   err_timeout             sticky: core failed to answer within TIMEOUT
// -----------------------------------------------------------------------------
module sha_msg_sequencer
    import sha_pkg::*;
#(
    parameter int unsigned BLOCK_W  = SHA_BLOCK_W,
    parameter int unsigned DIGEST_W = SHA_DIGEST_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BLOCK_W-1:0]  s_block,
    input  logic                s_last,
    output logic [BLOCK_W-1:0]  core_block,
    output logic                core_init,
    output logic                core_next,
    input  logic                core_ready,
    input  logic [DIGEST_W-1:0] core_digest,
    input  logic                core_digest_valid,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DIGEST_W-1:0] m_digest,
    output logic [15:0]         m_blk_count,
    output logic                err_timeout
);

    localparam int unsigned ENTRY_W = BLOCK_W + 1;
    localparam int unsigned TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;

    logic                 r_rdy_en;
    logic [BLOCK_W-1:0]   r_core_block;
    logic                 r_cur_last;
    logic                 r_first;
    logic [15:0]          r_blk_cnt;
    logic [15:0]          r_m_blk_count;
    logic                 r_m_valid;
    logic [DIGEST_W-1:0]  r_m_digest;
    logic                 r_err;
    logic [TW-1:0]        r_tcnt;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_init;
    logic                 w_next;
    logic [ENTRY_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]   w_head;

    // r_rdy_en keeps s_ready low while reset is held; occupancy alone
    // decides acceptance, so a full FIFO refuses even when popping.
    assign s_ready     = r_rdy_en && !w_fifo_full && (r_state != ST_ERR);
    assign w_push      = s_valid && s_ready;
    assign w_push_data = {s_block, s_last};
    assign w_flush     = (r_state == ST_ERR);

    sha_blk_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (w_flush),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Core pulses are decoded from ISSUE and core_ready so that a pop is
    // followed by the pulse in the very next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_init      = 1'b0;
        w_next      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core_ready) begin
                    w_init      = r_first;
                    w_next      = !r_first;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_digest_valid) begin
                    w_state_nxt = r_cur_last ? ST_HOLD : ST_IDLE;
                end else if (r_tcnt == T_LAST) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_HOLD: begin
                // m_valid is always high in HOLD
                if (m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en      <= 1'b0;
            r_core_block  <= '0;
            r_cur_last    <= 1'b0;
            r_first       <= 1'b1;
            r_blk_cnt     <= '0;
            r_m_blk_count <= '0;
            r_m_valid     <= 1'b0;
            r_m_digest    <= '0;
            r_err         <= 1'b0;
            r_tcnt        <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_core_block <= w_head[ENTRY_W-1:1];
                        r_cur_last   <= w_head[0];
                    end
                end
                ST_ISSUE: begin
                    if (core_ready) begin
                        r_first <= 1'b0;
                        r_tcnt  <= '0;
                    end
                end
                ST_WAIT: begin
                    if (core_digest_valid) begin
                        r_blk_cnt <= sat_inc16(r_blk_cnt);
                        if (r_cur_last) begin
                            r_m_digest    <= core_digest;
                            r_m_valid     <= 1'b1;
                            r_m_blk_count <= sat_inc16(r_blk_cnt);
                        end
                    end else if (r_tcnt == T_LAST) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_first   <= 1'b1;
                        r_blk_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign core_block  = r_core_block;
    assign core_init   = w_init;
    assign core_next   = w_next;
    assign m_valid     = r_m_valid;
    assign m_digest    = r_m_digest;
    assign m_blk_count = r_m_blk_count;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_sha_msg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sha_msg_sequencer
// Directed bench: a behavioural SHA core answers each pulse after a chosen
// latency with a digest derived from the block; a second instance with a
// silent core exercises the timeout path.
// -----------------------------------------------------------------------------
module tb_sha_msg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rst2_n;

    // main instance
    logic         s_valid, s_ready, s_last;
    logic [511:0] s_block;
    logic [511:0] core_block;
    logic         core_init, core_next, core_ready;
    logic [255:0] core_digest, w_core_digest;
    logic         core_dv, w_core_dv;
    logic         m_valid, m_ready;
    logic [255:0] m_digest;
    logic [15:0]  m_blk_count;
    logic         err_timeout;
    logic         spur;
    logic [255:0] spur_dig;

    assign w_core_dv     = core_dv | spur;
    assign w_core_digest = spur ? spur_dig : core_digest;

    // timeout instance
    logic         s2_valid, s2_ready, s2_last;
    logic [31:0]  s2_block;
    logic [31:0]  c2_block;
    logic         c2_init, c2_next, c2_ready;
    logic [31:0]  c2_dig;
    logic         c2_dv;
    logic         m2_valid, m2_ready;
    logic [31:0]  m2_digest;
    logic [15:0]  m2_cnt;
    logic         err2;

    sha_msg_sequencer #(
        .BLOCK_W  (512),
        .DIGEST_W (256),
        .DEPTH    (4),
        .TIMEOUT  (1024)
    ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_block           (s_block),
        .s_last            (s_last),
        .core_block        (core_block),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_ready        (core_ready),
        .core_digest       (w_core_digest),
        .core_digest_valid (w_core_dv),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_digest          (m_digest),
        .m_blk_count       (m_blk_count),
        .err_timeout       (err_timeout)
    );

    sha_msg_sequencer #(
        .BLOCK_W  (32),
        .DIGEST_W (32),
        .DEPTH    (4),
        .TIMEOUT  (16)
    ) u_dut_to (
        .clk               (clk),
        .rst_n             (rst2_n),
        .s_valid           (s2_valid),
        .s_ready           (s2_ready),
        .s_block           (s2_block),
        .s_last            (s2_last),
        .core_block        (c2_block),
        .core_init         (c2_init),
        .core_next         (c2_next),
        .core_ready        (c2_ready),
        .core_digest       (c2_dig),
        .core_digest_valid (c2_dv),
        .m_valid           (m2_valid),
        .m_ready           (m2_ready),
        .m_digest          (m2_digest),
        .m_blk_count       (m2_cnt),
        .err_timeout       (err2)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] dig(input logic [511:0] b);
        return b[511:256] ^ {b[127:0], b[255:128]} ^ {8{32'h5A5AC3C3}};
    endfunction

    function automatic logic [511:0] mk(input logic [31:0] k);
        return {16{32'hA5A50000 ^ k}};
    endfunction

    // behavioural core: answers each pulse core_lat cycles later
    int unsigned  core_lat = 64;
    int unsigned  n_init = 0, n_next = 0, n_both = 0, p_n = 0;
    int unsigned  p_log [64];
    logic [511:0] cm_blk;

    initial begin : core_model
        core_ready  = 1'b1;
        core_dv     = 1'b0;
        core_digest = '0;
        forever begin
            @(negedge clk);
            if (core_init || core_next) begin
                if (core_init && core_next) n_both++;
                if (core_init) n_init++;
                else n_next++;
                if (p_n < 64) p_log[p_n] = core_init ? 1 : 2;
                p_n++;
                cm_blk = core_block;
                @(negedge clk);
                core_ready = 1'b0;
                repeat (core_lat - 1) @(negedge clk);
                core_digest = dig(cm_blk);
                core_dv     = 1'b1;
                @(negedge clk);
                core_dv     = 1'b0;
                core_ready  = 1'b1;
            end
        end
    end

    int unsigned n2_pulse = 0;
    always @(negedge clk) begin
        if (c2_init || c2_next) n2_pulse <= n2_pulse + 1;
    end

    task automatic push(input logic [511:0] b, input logic l);
        int unsigned n = 0;
        s_block = b;
        s_last  = l;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 256'(s_ready), 256'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_mv(input string tag);
        int unsigned n = 0;
        while (m_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 256'(m_valid), 256'd1);
    endtask

    task automatic ack();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned  base;
        int unsigned  n;
        logic [511:0] blk;

        rst_n = 1'b0;  rst2_n = 1'b0;
        s_valid = 1'b0; s_block = '0; s_last = 1'b0; m_ready = 1'b0;
        spur = 1'b0; spur_dig = '0;
        s2_valid = 1'b0; s2_block = '0; s2_last = 1'b0;
        c2_ready = 1'b1; c2_dig = '0; c2_dv = 1'b0; m2_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_s_ready",    256'(s_ready), 256'd0);
        chk("rst_pulses",     256'({core_init, core_next}), 256'd0);
        chk("rst_core_block", 256'(core_block != '0), 256'd0);
        chk("rst_m_valid",    256'(m_valid), 256'd0);
        chk("rst_m_digest",   m_digest, 256'd0);
        chk("rst_blk_count",  256'(m_blk_count), 256'd0);
        chk("rst_err",        256'(err_timeout), 256'd0);
        rst_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_rst", 256'(s_ready), 256'd1);

        // single-block message, 64-cycle core
        core_lat = 64;
        blk = mk(32'd1);
        push(blk, 1'b1);
        @(negedge clk);
        chk("pop_to_pulse", 256'(core_init), 256'd1);
        chk("pulse_block",  256'(core_block == blk), 256'd1);
        repeat (20) @(negedge clk);
        chk("block_stable_wait", 256'(core_block == blk), 256'd1);
        chk("no_mvalid_early",   256'(m_valid), 256'd0);
        wait_mv("mv_single");
        chk("single_n_init", 256'(n_init), 256'd1);
        chk("single_n_next", 256'(n_next), 256'd0);
        chk("single_digest", m_digest, dig(blk));
        chk("single_count",  256'(m_blk_count), 256'd1);

        // spurious digest in HOLD
        spur_dig = ~dig(blk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_mvalid",      256'(m_valid), 256'd1);
        chk("hold_digest_spur", m_digest, dig(blk));
        chk("hold_count",       256'(m_blk_count), 256'd1);
        ack();
        chk("ack_drop", 256'(m_valid), 256'd0);

        // spurious digest in IDLE
        base = p_n;
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_spur_mvalid",  256'(m_valid), 256'd0);
        chk("idle_spur_digest",  m_digest, dig(blk));
        chk("idle_spur_nopulse", 256'(p_n - base), 256'd0);

        // three-block message
        core_lat = 5;
        base = p_n;
        push(mk(32'd10), 1'b0);
        push(mk(32'd11), 1'b0);
        push(mk(32'd12), 1'b1);
        wait_mv("mv_three");
        chk("three_pulses", 256'(p_n - base), 256'd3);
        chk("three_seq0",   256'(p_log[base]),     256'd1);
        chk("three_seq1",   256'(p_log[base + 1]), 256'd2);
        chk("three_seq2",   256'(p_log[base + 2]), 256'd2);
        chk("three_count",  256'(m_blk_count), 256'd3);
        chk("three_digest", m_digest, dig(mk(32'd12)));
        ack();

        // five single-block messages, downstream stalled
        core_lat = 3;
        base = p_n;
        for (int i = 0; i < 5; i++) push(mk(32'(20 + i)), 1'b1);
        chk("full_s_ready_low", 256'(s_ready), 256'd0);
        repeat (100) @(negedge clk);
        chk("stall_s_ready", 256'(s_ready), 256'd0);
        chk("stall_pulses",  256'(p_n - base), 256'd1);
        for (int i = 0; i < 5; i++) begin
            wait_mv("mv_burst");
            chk("burst_digest", m_digest, dig(mk(32'(20 + i))));
            chk("burst_count",  256'(m_blk_count), 256'd1);
            ack();
        end
        chk("burst_pulses",      256'(p_n - base), 256'd5);
        chk("burst_all_init",    256'(n_next), 256'd2);
        chk("ready_after_drain", 256'(s_ready), 256'd1);

        // reset during WAIT of the second block
        core_lat = 50;
        base = p_n;
        push(mk(32'd40), 1'b0);
        push(mk(32'd41), 1'b0);
        push(mk(32'd42), 1'b1);
        n = 0;
        while (p_n < base + 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("mid_second_pulse", 256'(p_n - base), 256'd2);
        repeat (5) @(negedge clk);
        chk("mid_wait_block", 256'(core_block == mk(32'd41)), 256'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_ready",    256'(s_ready), 256'd0);
        chk("arst_m_valid",    256'(m_valid), 256'd0);
        chk("arst_core_block", 256'(core_block != '0), 256'd0);
        chk("arst_m_digest",   m_digest, 256'd0);
        chk("arst_count",      256'(m_blk_count), 256'd0);
        chk("arst_pulses",     256'({core_init, core_next}), 256'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (core_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("core_idle_again", 256'(core_ready), 256'd1);
        repeat (5) @(negedge clk);
        chk("flush_no_pulse", 256'(p_n - base), 256'd2);
        chk("post_rst_ready", 256'(s_ready), 256'd1);
        chk("post_rst_mvalid", 256'(m_valid), 256'd0);
        core_lat = 4;
        blk = mk(32'd50);
        push(blk, 1'b1);
        wait_mv("mv_post_rst");
        chk("post_rst_init",   256'(p_log[p_n - 1]), 256'd1);
        chk("post_rst_count",  256'(m_blk_count), 256'd1);
        chk("post_rst_digest", m_digest, dig(blk));
        ack();

        // timeout instance: core never answers, TIMEOUT = 16
        s2_block = 32'hC0FFEE01;
        s2_last  = 1'b0;
        s2_valid = 1'b1;
        @(negedge clk);
        s2_valid = 1'b0;
        n = 0;
        while (c2_init !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("to_pulse", 256'(c2_init), 256'd1);
        chk("to_block", 256'(c2_block), 256'(32'hC0FFEE01));
        s2_block = 32'hC0FFEE02;
        s2_valid = 1'b1;
        @(negedge clk);
        s2_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("to_not_yet", 256'(err2), 256'd0);
        @(negedge clk);
        chk("to_err",     256'(err2), 256'd1);
        chk("to_s_ready", 256'(s2_ready), 256'd0);
        repeat (30) @(negedge clk);
        chk("to_no_more_pulses", 256'(n2_pulse), 256'd1);
        chk("to_sticky",  256'(err2), 256'd1);
        chk("to_ready_stays_low", 256'(s2_ready), 256'd0);
        chk("to_m_valid", 256'(m2_valid), 256'd0);
        chk("to_m_digest", 256'(m2_digest), 256'd0);
        chk("to_m_cnt",   256'(m2_cnt), 256'd0);

        chk("no_double_pulse", 256'(n_both), 256'd0);
        chk("main_no_timeout", 256'(err_timeout), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
